tone_scheduler: RTL and testbench

//  Speaker-sharing arbiter and sequencer for the Simon top level. It takes the lamp

---
 rtl/tone_pkg.sv | 43 ++++
 rtl/tone_gen.sv | 43 ++++
 rtl/tone_scheduler.sv | 177 +++++++++++++++++
 tb/tb_tone_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and half-period tables for the Simon speaker scheduler.
//   src_t   : audio source reported on the src port
//   state_t : scheduler FSM states
//   base_hp : half-period lookup (50 MHz clk cycles) for a source/note/colour
package tone_pkg;

  localparam int HP_W = 17;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_LAMP = 3'd1,
    SRC_WIN  = 3'd2,
    SRC_LOSE = 3'd3,
    SRC_HS   = 3'd4
  } src_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LAMP, ST_NOTE, ST_GAP} state_t;

  // Bit positions inside the pending-jingle vector
  localparam int PB_WIN  = 0;
  localparam int PB_LOSE = 1;
  localparam int PB_HS   = 2;

  localparam logic [HP_W-1:0] COLOUR_HP [4] = '{17'd119617, 17'd99206, 17'd80645, 17'd60241};
  localparam logic [HP_W-1:0] WIN_HP    [4] = '{17'd80645, 17'd60241, 17'd50000, 17'd40000};
  localparam logic [HP_W-1:0] LOSE_HP   [4] = '{17'd60241, 17'd80645, 17'd99206, 17'd119617};
  localparam logic [HP_W-1:0] HS_HP     [4] = '{17'd60241, 17'd40000, 17'd60241, 17'd40000};

  function automatic logic [HP_W-1:0] base_hp(input src_t s, input logic [1:0] idx,
                                              input logic [1:0] code);
    logic [HP_W-1:0] r;
    r = '0;
    case (s)
      SRC_LAMP: r = COLOUR_HP[code];
      SRC_WIN:  r = WIN_HP[idx];
      SRC_LOSE: r = LOSE_HP[idx];
      SRC_HS:   r = HS_HP[idx];
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: spk toggles every hp cycles.
//   clk, rst_n : clock, async active-low reset
//   restart    : clears counter and spk (held high while silent)
//   hp         : half-period in clk cycles, must be >= 1
//   spk        : square-wave output
module tone_gen
  import tone_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            restart,
  input  logic [HP_W-1:0] hp,
  output logic            spk
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            spk_q, spk_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    spk_d = spk_q;
    if (restart) begin
      cnt_d = '0;
      spk_d = 1'b0;
    end else if (cnt_q >= hp - 1'b1) begin
      cnt_d = '0;
      spk_d = ~spk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      spk_q <= spk_d;
    end
  end

  assign spk = spk_q;

endmodule

// File: rtl/tone_scheduler.sv
// Speaker arbiter/sequencer: lamp colour tones plus queued 4-note event jingles.
//   clk, rst_n     : clock, async active-low reset
//   lamp_code/ena  : colour of lit lamp, level-sensitive enable
//   win/lose/hs    : rising-edge jingle requests
//   spk            : speaker square wave
//   busy           : jingle playing or pending
//   src            : 0 none, 1 lamp, 2 win, 3 lose, 4 hs
module tone_scheduler
  import tone_pkg::*;
#(
  parameter int TICK_DIV       = 50_000,
  parameter int NOTE_TICKS     = 150,
  parameter int GAP_TICKS      = 30,
  parameter int TONE_DIV_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] lamp_code,
  input  logic       lamp_ena,
  input  logic       win,
  input  logic       lose,
  input  logic       hs,
  output logic       spk,
  output logic       busy,
  output logic [2:0] src
);

  localparam int MAXT = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int PW   = $clog2(TICK_DIV + 1);
  localparam int TW   = $clog2(MAXT + 1);

  state_t          state_q, state_d;
  src_t            src_q, src_d;
  logic [2:0]      pend_q, pend_d, pend_clr, req;
  logic [2:0]      in_q, in_d;
  logic [1:0]      note_q, note_d;
  logic [1:0]      code_q, code_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            playing, tick_end, phase_end, restart;
  int              phase_ticks;
  src_t            pick_src;
  logic [2:0]      pick_mask;
  logic [HP_W-1:0] hp_raw, hp;

  assign playing = (state_q == ST_NOTE) || (state_q == ST_GAP);

  // Rising edges; a request for the jingle already playing is dropped.
  always_comb begin
    in_d   = {hs, lose, win};
    code_d = lamp_code;
    req    = in_d & ~in_q;
    if (playing) begin
      if (src_q == SRC_WIN)  req[PB_WIN]  = 1'b0;
      if (src_q == SRC_LOSE) req[PB_LOSE] = 1'b0;
      if (src_q == SRC_HS)   req[PB_HS]   = 1'b0;
    end
  end

  // Highest-priority pending jingle: lose > hs > win
  always_comb begin
    pick_src  = SRC_WIN;
    pick_mask = 3'b001;
    if (pend_q[PB_LOSE]) begin
      pick_src  = SRC_LOSE;
      pick_mask = 3'b010;
    end else if (pend_q[PB_HS]) begin
      pick_src  = SRC_HS;
      pick_mask = 3'b100;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    note_d      = note_q;
    pend_clr    = '0;
    phase_ticks = (state_q == ST_NOTE) ? NOTE_TICKS : GAP_TICKS;
    tick_end    = (presc_q == PW'(TICK_DIV - 1));
    phase_end   = tick_end && (tcnt_q == TW'(phase_ticks - 1));
    if (tick_end) begin
      presc_d = '0;
      tcnt_d  = tcnt_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
      tcnt_d  = tcnt_q;
    end

    case (state_q)
      ST_IDLE, ST_LAMP: begin
        if (pend_q != '0) begin
          state_d  = ST_NOTE;
          src_d    = pick_src;
          pend_clr = pick_mask;
          note_d   = '0;
        end else if (state_q == ST_IDLE && lamp_ena) begin
          state_d = ST_LAMP;
          src_d   = SRC_LAMP;
        end else if (state_q == ST_LAMP && !lamp_ena) begin
          state_d = ST_IDLE;
          src_d   = SRC_NONE;
        end
      end
      ST_NOTE: if (phase_end) state_d = ST_GAP;
      ST_GAP: begin
        if (phase_end) begin
          if (note_q != 2'd3) begin
            state_d = ST_NOTE;
            note_d  = note_q + 1'b1;
          end else if (pend_q != '0) begin
            state_d  = ST_NOTE;
            src_d    = pick_src;
            pend_clr = pick_mask;
            note_d   = '0;
          end else if (lamp_ena) begin
            state_d = ST_LAMP;
            src_d   = SRC_LAMP;
          end else begin
            state_d = ST_IDLE;
            src_d   = SRC_NONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timing restarts on every NOTE/GAP entry so each phase length is exact
    if (state_d != state_q || !(state_d inside {ST_NOTE, ST_GAP})) begin
      presc_d = '0;
      tcnt_d  = '0;
    end

    pend_d = (pend_q | req) & ~pend_clr;
  end

  // Tone restarts on any state entry, on a colour change while lit, and is
  // held cleared whenever the speaker should be silent.
  assign restart = (state_d != state_q) || !(state_d inside {ST_LAMP, ST_NOTE}) ||
                   (state_q == ST_LAMP && lamp_code != code_q);

  assign hp_raw = base_hp(src_q, note_q, code_q) >> TONE_DIV_SHIFT;
  assign hp     = (hp_raw == '0) ? HP_W'(1) : hp_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_NONE;
      pend_q  <= '0;
      in_q    <= '0;
      note_q  <= '0;
      code_q  <= '0;
      presc_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      pend_q  <= pend_d;
      in_q    <= in_d;
      note_q  <= note_d;
      code_q  <= code_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
    end
  end

  tone_gen u_tone (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .hp      (hp),
    .spk     (spk)
  );

  assign busy = playing || (pend_q != '0);
  assign src  = src_q;

endmodule

// File: tb/tb_tone_scheduler.sv
module tb_tone_scheduler;

  localparam int LIMIT = 1200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] lamp_code = 2'd0;
  logic       lamp_ena = 1'b0, win = 1'b0, lose = 1'b0, hs = 1'b0, win2 = 1'b0;
  logic       spk, busy, spk2, busy2;
  logic [2:0] src, src2;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  // Main instance with the short test timing
  tone_scheduler #(.TICK_DIV(4), .NOTE_TICKS(3), .GAP_TICKS(1), .TONE_DIV_SHIFT(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .lamp_code(lamp_code), .lamp_ena(lamp_ena),
    .win(win), .lose(lose), .hs(hs), .spk(spk), .busy(busy), .src(src)
  );

  // Long-note instance so jingle tones actually toggle within a note
  tone_scheduler #(.TICK_DIV(4), .NOTE_TICKS(60), .GAP_TICKS(1), .TONE_DIV_SHIFT(10)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .lamp_code(2'd0), .lamp_ena(1'b0),
    .win(win2), .lose(1'b0), .hs(1'b0), .spk(spk2), .busy(busy2), .src(src2)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input int obs);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed %0d expected <scoreboard empty>", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  // Cycles until src changes; records spk high / busy low seen before the change
  task automatic wait_src(input bit sel, output int val, output int n,
                          output bit spk_hi, output bit busy_lo);
    logic [2:0] prev, cur;
    prev = sel ? src2 : src;
    n = 0; val = -1; spk_hi = 1'b0; busy_lo = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      n++;
      cur = sel ? src2 : src;
      if (cur != prev) begin
        val = int'(cur);
        return;
      end
      if ((sel ? spk2 : spk) === 1'b1) spk_hi = 1'b1;
      if ((sel ? busy2 : busy) !== 1'b1) busy_lo = 1'b1;
    end
    n = -1;
  endtask

  task automatic wait_spk(input bit sel, output int n);
    logic prev;
    prev = sel ? spk2 : spk;
    n = 0;
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      n++;
      if ((sel ? spk2 : spk) != prev) return;
    end
    n = -1;
  endtask

  int v, n, sum;
  bit shi, blo;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst src", src, 0);
    check("rst busy", busy, 0);
    check("rst spk", spk, 0);
    rst_n = 1'b1;
    tick();

    // Jingle tone on the long-note instance: win note0 hp=78, note1 hp=58
    exp_q.push_back(2); exp_q.push_back(1);
    exp_q.push_back(78); exp_q.push_back(78); exp_q.push_back(78);
    exp_q.push_back(6); exp_q.push_back(62);
    win2 = 1'b1; tick(); win2 = 1'b0;
    wait_src(1, v, n, shi, blo);
    sb_check("j2 src", v); sb_check("j2 lat", n);
    for (int k = 0; k < 5; k++) begin
      wait_spk(1, n);
      sb_check("j2 spk edge", n);
    end

    // 1. Lamp colour 3 -> hp=58
    exp_q.push_back(1); exp_q.push_back(1);
    exp_q.push_back(58); exp_q.push_back(58); exp_q.push_back(58);
    lamp_code = 2'd3; lamp_ena = 1'b1;
    wait_src(0, v, n, shi, blo);
    sb_check("t1 src", v); sb_check("t1 lat", n);
    for (int k = 0; k < 3; k++) begin
      wait_spk(0, n);
      sb_check("t1 half", n);
    end
    check("t1 spk hi", spk, 1);
    lamp_ena = 1'b0;
    tick();
    check("t1 off spk", spk, 0);
    check("t1 off src", src, 0);

    // 2. Single win jingle
    exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(64);
    win = 1'b1; tick();
    check("t2 busy pend", busy, 1);
    check("t2 src pend", src, 0);
    win = 1'b0;
    wait_src(0, v, n, shi, blo);
    sb_check("t2 src", v); sb_check("t2 lat", n);
    wait_src(0, v, n, shi, blo);
    sb_check("t2 end src", v); sb_check("t2 len", n);
    check("t2 silent", shi, 0);
    check("t2 busy held", blo, 0);
    check("t2 busy end", busy, 0);

    // 3. Simultaneous win+lose+hs -> lose, hs, win
    exp_q.push_back(3); exp_q.push_back(1);
    exp_q.push_back(4); exp_q.push_back(64);
    exp_q.push_back(2); exp_q.push_back(64);
    exp_q.push_back(0); exp_q.push_back(64);
    win = 1'b1; lose = 1'b1; hs = 1'b1; tick();
    check("t3 busy pend", busy, 1);
    win = 1'b0; lose = 1'b0; hs = 1'b0;
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      wait_src(0, v, n, shi, blo);
      sb_check("t3 src", v); sb_check("t3 len", n);
      if (k > 0) sum += n;
      check("t3 busy held", blo, 0);
    end
    check("t3 busy span", sum, 192);
    check("t3 busy end", busy, 0);

    // 4. Lamp pre-empted by lose, then lamp resumes with fresh tone (hp=116)
    exp_q.push_back(1); exp_q.push_back(1);
    lamp_code = 2'd0; lamp_ena = 1'b1;
    wait_src(0, v, n, shi, blo);
    sb_check("t4 src", v); sb_check("t4 lat", n);
    repeat (10) tick();
    exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(64);
    exp_q.push_back(116); exp_q.push_back(116); exp_q.push_back(0); exp_q.push_back(1);
    lose = 1'b1; tick();
    check("t4 pend src", src, 1);
    check("t4 pend busy", busy, 1);
    lose = 1'b0;
    wait_src(0, v, n, shi, blo);
    sb_check("t4 preempt src", v); sb_check("t4 preempt lat", n);
    wait_src(0, v, n, shi, blo);
    sb_check("t4 resume src", v); sb_check("t4 jingle len", n);
    for (int k = 0; k < 2; k++) begin
      wait_spk(0, n);
      sb_check("t4 half", n);
    end
    lamp_ena = 1'b0;
    wait_src(0, v, n, shi, blo);
    sb_check("t4 off src", v); sb_check("t4 off lat", n);

    // 5. Re-pulse win during win jingle is ignored
    exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(43);
    win = 1'b1; tick(); win = 1'b0;
    wait_src(0, v, n, shi, blo);
    sb_check("t5 src", v); sb_check("t5 lat", n);
    repeat (20) tick();
    win = 1'b1; tick(); win = 1'b0;
    wait_src(0, v, n, shi, blo);
    sb_check("t5 end src", v); sb_check("t5 rest", n);
    repeat (5) tick();
    check("t5 busy after", busy, 0);
    check("t5 src after", src, 0);

    // 6. Async reset mid-NOTE
    exp_q.push_back(2); exp_q.push_back(1);
    win = 1'b1; tick(); win = 1'b0;
    wait_src(0, v, n, shi, blo);
    sb_check("t6 src", v); sb_check("t6 lat", n);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6 async src", src, 0);
    check("t6 async busy", busy, 0);
    check("t6 async spk", spk, 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("t6 post src", src, 0);
    check("t6 post busy", busy, 0);

    check("sb drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
